mem_lsu: RTL and testbench

Load/store unit for the MEM stage of the MINA2000 pipeline. Issues one data-bus transaction per load or store held in EX/MEM and stalls the pipeline (`mem_stall`) until the bus responds. It returns sign- or zero-extended load data to MEM/WB. It is the producing end of the load result that the ID-stage load-use stall waits on.

---
 rtl/types_pkg.sv | 32 +++
 rtl/mem_lsu_load_align.sv | 23 ++
 rtl/mem_lsu.sv | 159 +++++++++++++++
 tb/tb_mem_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared pipeline types for the MINA2000 core: operand encodings and LSU state.
package types;

  typedef logic [4:0] regaddr_t;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2
  } lsu_state_e;

  function automatic logic is_misaligned(mem_size_e size, logic [1:0] off);
    case (size)
      MEM_SIZE_HALF: return off[0];
      MEM_SIZE_WORD: return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and extends it.
module load_align
  import types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  mem_size_e   size,
  input  logic        sgn,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      MEM_SIZE_BYTE: result = {{24{sgn & shifted[7]}}, shifted[7:0]};
      MEM_SIZE_HALF: result = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default:       result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus transaction per load/store, stalls the
// pipeline until the response arrives and returns extended load data.
//
// state    | meaning
// LSU_IDLE | no transaction; a new op issues straight from the EX/MEM inputs
// LSU_REQ  | request pending on the bus, not yet accepted
// LSU_RSP  | request accepted, waiting for the completion pulse
module mem_lsu
  import types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  mem_op_e     mem_op,
  input  mem_size_e   mem_size,
  input  logic        mem_signed,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  regaddr_t    rd_addr,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_be,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        load_valid,
  output logic [31:0] load_data,
  output regaddr_t    load_rd_addr
);

  lsu_state_e  state, state_nxt;
  logic        active;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  mem_op_e     lat_op;
  mem_size_e   lat_size;
  logic        lat_signed;
  logic [1:0]  lat_off;
  logic [29:0] lat_waddr;
  regaddr_t    lat_rd;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;
  logic [31:0] aligned;

  assign misaligned = (mem_op != MEM_OP_NONE) && is_misaligned(mem_size, addr[1:0]);
  assign active     = (mem_op != MEM_OP_NONE) && !misaligned;

  always_comb begin
    case (mem_size)
      MEM_SIZE_BYTE: begin
        in_be    = 4'b0001 << addr[1:0];
        in_wdata = {4{store_data[7:0]}};
      end
      MEM_SIZE_HALF: begin
        in_be    = 4'b0011 << {addr[1], 1'b0};
        in_wdata = {2{store_data[15:0]}};
      end
      default: begin
        in_be    = 4'b1111;
        in_wdata = store_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (active) state_nxt = bus_req_ready ? LSU_RSP : LSU_REQ;
      LSU_REQ:  if (bus_req_ready) state_nxt = LSU_RSP;
      LSU_RSP:  if (bus_rsp_valid) state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_comb begin
    bus_req_valid = 1'b0;
    mem_stall     = 1'b0;
    bus_req_write = lat_op == MEM_OP_STORE;
    bus_req_addr  = {lat_waddr, 2'b00};
    bus_req_wdata = lat_wdata;
    bus_req_be    = lat_be;
    case (state)
      LSU_IDLE: begin
        bus_req_valid = active;
        mem_stall     = active;
        bus_req_write = mem_op == MEM_OP_STORE;
        bus_req_addr  = {addr[31:2], 2'b00};
        bus_req_wdata = in_wdata;
        bus_req_be    = in_be;
      end
      LSU_REQ: begin
        bus_req_valid = 1'b1;
        mem_stall     = 1'b1;
      end
      LSU_RSP: mem_stall = !bus_rsp_valid;
      default: ;
    endcase
    // Nothing may leave the LSU while reset is held, whatever the inputs say.
    if (!rst_n) begin
      bus_req_valid = 1'b0;
      mem_stall     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_op     <= MEM_OP_NONE;
      lat_size   <= MEM_SIZE_BYTE;
      lat_signed <= 1'b0;
      lat_off    <= 2'b00;
      lat_waddr  <= '0;
      lat_rd     <= '0;
      lat_be     <= '0;
      lat_wdata  <= '0;
    end else if (state == LSU_IDLE && active) begin
      lat_op     <= mem_op;
      lat_size   <= mem_size;
      lat_signed <= mem_signed;
      lat_off    <= addr[1:0];
      lat_waddr  <= addr[31:2];
      lat_rd     <= rd_addr;
      lat_be     <= in_be;
      lat_wdata  <= in_wdata;
    end
  end

  load_align u_load_align (
    .rdata  (bus_rsp_rdata),
    .off    (lat_off),
    .size   (lat_size),
    .sgn    (lat_signed),
    .result (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid   <= 1'b0;
      load_data    <= '0;
      load_rd_addr <= '0;
    end else begin
      load_valid <= 1'b0;
      if (state == LSU_RSP && bus_rsp_valid && lat_op == MEM_OP_LOAD) begin
        load_valid   <= 1'b1;
        load_data    <= aligned;
        load_rd_addr <= lat_rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table with a bus responder,
// scoreboard for load results, plus reset/misalignment sequences.
module tb_mem_lsu;
  import types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  mem_op_e     mem_op = MEM_OP_NONE;
  mem_size_e   mem_size = MEM_SIZE_WORD;
  logic        mem_signed = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  regaddr_t    rd_addr = '0;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_be;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;
  logic        mem_stall;
  logic        misaligned;
  logic        load_valid;
  logic [31:0] load_data;
  regaddr_t    load_rd_addr;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .mem_size(mem_size),
    .mem_signed(mem_signed), .addr(addr), .store_data(store_data), .rd_addr(rd_addr),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .mem_stall(mem_stall), .misaligned(misaligned), .load_valid(load_valid),
    .load_data(load_data), .load_rd_addr(load_rd_addr)
  );

  typedef struct {
    mem_op_e     op;
    mem_size_e   size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] sdata;
    regaddr_t    rd;
    logic [31:0] rdata;
    int          wait_cyc;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    regaddr_t    rd;
  } exp_t;

  vec_t vec[9];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && load_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_load_valid", 32'(load_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("load_data", load_data, e.data);
        check("load_rd_addr", 32'(load_rd_addr), 32'(e.rd));
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b0;
    mem_op        = MEM_OP_NONE;
  endtask

  // Issue one op, hold off ready for wait_cyc cycles, then return the response.
  // Leaves bus_rsp_valid high in the RSP cycle so the next call can issue back-to-back.
  task automatic do_op(input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    mem_op        = v.op;
    mem_size      = v.size;
    mem_signed    = v.sgn;
    addr          = v.addr;
    store_data    = v.sdata;
    rd_addr       = v.rd;
    bus_req_ready = (v.wait_cyc == 0);
    #1;
    check("issue_valid", 32'(bus_req_valid), 32'd1);
    check("issue_write", 32'(bus_req_write), 32'(v.op == MEM_OP_STORE));
    check("issue_addr", bus_req_addr, exp_addr);
    check("issue_be", 32'(bus_req_be), 32'(v.be));
    if (v.op == MEM_OP_STORE) check("issue_wdata", bus_req_wdata, v.wdata);
    check("issue_stall", 32'(mem_stall), 32'd1);
    check("issue_misaligned", 32'(misaligned), 32'd0);
    if (v.op == MEM_OP_LOAD) sb.push_back('{data: v.ldata, rd: v.rd});
    for (int i = 0; i < v.wait_cyc; i++) begin
      @(posedge clk); #1;
      addr       = v.addr ^ 32'h0000_0100;
      store_data = ~v.sdata;
      rd_addr    = ~v.rd;
      if (i == v.wait_cyc - 1) bus_req_ready = 1'b1;
      #1;
      check("req_valid_held", 32'(bus_req_valid), 32'd1);
      check("req_addr_held", bus_req_addr, exp_addr);
      check("req_be_held", 32'(bus_req_be), 32'(v.be));
      if (v.op == MEM_OP_STORE) check("req_wdata_held", bus_req_wdata, v.wdata);
      check("req_stall", 32'(mem_stall), 32'd1);
    end
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    mem_op        = MEM_OP_NONE;
    addr          = '0;
    store_data    = '0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = v.rdata;
    #1;
    check("rsp_stall", 32'(mem_stall), 32'd0);
    check("rsp_no_req", 32'(bus_req_valid), 32'd0);
  endtask

  initial begin
    //          op            size           sgn   addr          sdata         rd     rdata         wait be       wdata         ldata
    vec[0] = '{MEM_OP_LOAD,  MEM_SIZE_BYTE, 1'b1, 32'h0000_1003, 32'h0,        5'd5,  32'h80FF_0000, 0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vec[1] = '{MEM_OP_LOAD,  MEM_SIZE_HALF, 1'b0, 32'h0000_2002, 32'h0,        5'd7,  32'hBEEF_1234, 1, 4'b1100, 32'h0,        32'h0000_BEEF};
    vec[2] = '{MEM_OP_STORE, MEM_SIZE_BYTE, 1'b0, 32'h0000_0011, 32'h0000_00A5, 5'd0, 32'h0,        3, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vec[3] = '{MEM_OP_LOAD,  MEM_SIZE_WORD, 1'b1, 32'h0000_3000, 32'h0,        5'd9,  32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vec[4] = '{MEM_OP_LOAD,  MEM_SIZE_WORD, 1'b0, 32'h0000_3004, 32'h0,        5'd10, 32'h1234_5678, 0, 4'b1111, 32'h0,        32'h1234_5678};
    vec[5] = '{MEM_OP_LOAD,  MEM_SIZE_BYTE, 1'b0, 32'h0000_4001, 32'h0,        5'd3,  32'h0000_F000, 0, 4'b0010, 32'h0,        32'h0000_00F0};
    vec[6] = '{MEM_OP_LOAD,  MEM_SIZE_HALF, 1'b1, 32'h0000_4000, 32'h0,        5'd31, 32'h0000_8001, 2, 4'b0011, 32'h0,        32'hFFFF_8001};
    vec[7] = '{MEM_OP_STORE, MEM_SIZE_HALF, 1'b0, 32'h0000_5002, 32'h1234_CAFE, 5'd0, 32'h0,        0, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    vec[8] = '{MEM_OP_STORE, MEM_SIZE_WORD, 1'b0, 32'h0000_6000, 32'h0102_0304, 5'd0, 32'h0,        1, 4'b1111, 32'h0102_0304, 32'h0};

    // Reset state, with a load presented on the inputs to exercise the gating.
    mem_op = MEM_OP_LOAD; mem_size = MEM_SIZE_WORD; addr = 32'h100; bus_req_ready = 1'b1;
    #2;
    check("rst_req_valid", 32'(bus_req_valid), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_rd", 32'(load_rd_addr), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_op = MEM_OP_NONE; bus_req_ready = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vec[i]);
    idle_cycle();
    idle_cycle();

    // Misalignment is purely combinational; restore NONE before the next edge.
    @(posedge clk); #1;
    mem_op = MEM_OP_LOAD; mem_size = MEM_SIZE_WORD; addr = 32'h0000_1002;
    #1;
    check("mis_word_flag", 32'(misaligned), 32'd1);
    check("mis_word_valid", 32'(bus_req_valid), 32'd0);
    check("mis_word_stall", 32'(mem_stall), 32'd0);
    mem_op = MEM_OP_STORE; mem_size = MEM_SIZE_HALF; addr = 32'h0000_1001;
    #1;
    check("mis_half_flag", 32'(misaligned), 32'd1);
    check("mis_half_valid", 32'(bus_req_valid), 32'd0);
    mem_op = MEM_OP_NONE; mem_size = MEM_SIZE_WORD; addr = 32'h0000_1003;
    #1;
    check("mis_none_flag", 32'(misaligned), 32'd0);
    check("mis_none_valid", 32'(bus_req_valid), 32'd0);
    mem_op = MEM_OP_LOAD; mem_size = MEM_SIZE_BYTE; addr = 32'h0000_1003;
    #1;
    check("mis_byte_flag", 32'(misaligned), 32'd0);
    check("mis_byte_valid", 32'(bus_req_valid), 32'd1);
    mem_op = MEM_OP_NONE;
    @(posedge clk); #1;
    check("mis_stays_idle", 32'(mem_stall), 32'd0);

    // Reset while waiting for a response; the late response must be ignored.
    @(posedge clk); #1;
    mem_op = MEM_OP_LOAD; mem_size = MEM_SIZE_WORD; addr = 32'h0000_7000; rd_addr = 5'd12;
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    check("pre_rst_rsp_stall", 32'(mem_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(mem_stall), 32'd0);
    check("mid_rst_valid", 32'(bus_req_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_op = MEM_OP_NONE;
    #1;
    check("post_rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFF_FFFF;
    #1;
    check("late_rsp_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    check("late_rsp_load_valid", 32'(load_valid), 32'd0);

    // Unit still works normally after the aborted transaction.
    do_op(vec[3]);
    idle_cycle();
    idle_cycle();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
